// File: rtl/nn_pkg.sv
// nn_pkg: shared state encoding, default widths and quantise helper for the result stage
// Provides: state_t {IDLE, DRAIN}; default Q, ACC_W, OUT_W, SHIFT; quantise() at default widths.
package nn_pkg;
    localparam int Q     = 4;
    localparam int ACC_W = 20;
    localparam int OUT_W = 8;
    localparam int SHIFT = 4;

    typedef enum logic {IDLE, DRAIN} state_t;

    function automatic logic [OUT_W-1:0] quantise(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] v;
        v = acc >>> SHIFT;
        return acc[ACC_W-1] ? '0 : (|v[ACC_W-1:OUT_W]) ? '1 : v[OUT_W-1:0];
    endfunction
endpackage

// File: rtl/relu_sat_quant.sv
// relu_sat_quant: combinational ReLU, fixed right shift and unsigned saturation
// Ports: res_in (signed ACC_W accumulator result) -> q (unsigned OUT_W quantised value).
module relu_sat_quant #(
    parameter int ACC_W = 20,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4
) (
    input  logic signed [ACC_W-1:0] res_in,
    output logic        [OUT_W-1:0] q
);
    logic signed [ACC_W-1:0] v;

    // After ReLU v is non-negative, so any set bit above OUT_W means it exceeds the max code.
    always_comb begin
        v = res_in >>> SHIFT;
        q = res_in[ACC_W-1] ? '0 : (|v[ACC_W-1:OUT_W]) ? '1 : v[OUT_W-1:0];
    end
endmodule

// File: rtl/result_writeback.sv
// result_writeback: quantises and buffers accumulator results, then drains them over valid/ready
// Ports: clk, rst (sync, active-high); res_write/res_in capture a result; done starts a drain;
//        out_ready/out_valid handshake carries out_data, out_idx, out_last; busy flags DRAIN;
//        overflow_err is sticky when a result is dropped.
module result_writeback
    import nn_pkg::*;
#(
    parameter int Q     = nn_pkg::Q,
    parameter int ACC_W = nn_pkg::ACC_W,
    parameter int OUT_W = nn_pkg::OUT_W,
    parameter int SHIFT = nn_pkg::SHIFT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             res_write,
    input  logic [ACC_W-1:0] res_in,
    input  logic             done,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [Q-1:0]     out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             overflow_err
);
    localparam int DEPTH = 2**Q;

    state_t           state, state_next;
    logic [Q:0]       wr_cnt;
    logic [Q-1:0]     rd_ptr;
    logic [OUT_W-1:0] mem [DEPTH];
    logic [OUT_W-1:0] q;
    logic             accept;
    logic             fire;

    relu_sat_quant #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_quant (
        .res_in (res_in),
        .q      (q)
    );

    // wr_cnt[Q] set means the buffer is full. The last index compares in Q bits so a
    // full count (low bits 0) wraps to DEPTH-1.
    always_comb begin
        busy       = state == DRAIN;
        out_valid  = busy;
        out_data   = busy ? mem[rd_ptr] : '0;
        out_idx    = rd_ptr;
        out_last   = busy && (rd_ptr == wr_cnt[Q-1:0] - Q'(1));
        fire       = out_valid && out_ready;
        accept     = !busy && res_write && !wr_cnt[Q];
        state_next = state;
        if (!busy && done && (wr_cnt != '0 || accept))
            state_next = DRAIN;
        else if (fire && out_last)
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_cnt       <= '0;
            rd_ptr       <= '0;
            overflow_err <= 1'b0;
        end else begin
            state <= state_next;
            if (accept)
                wr_cnt <= wr_cnt + (Q+1)'(1);
            if (res_write && !accept)
                overflow_err <= 1'b1;
            if (fire) begin
                rd_ptr <= out_last ? '0 : rd_ptr + Q'(1);
                if (out_last)
                    wr_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_cnt[Q-1:0]] <= q;
    end
endmodule

// File: tb/tb_result_writeback.sv
module tb_result_writeback;
    logic        clk = 1'b0;
    logic        rst, res_write, done, out_ready;
    logic [19:0] res_in;
    logic        out_valid, out_last, busy, overflow_err;
    logic [7:0]  out_data;
    logic [3:0]  out_idx;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    result_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .res_write    (res_write),
        .res_in       (res_in),
        .done         (done),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .busy         (busy),
        .overflow_err (overflow_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [19:0] v);
        res_write = 1'b1;
        res_in    = v;
        tick();
        res_write = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic beat(input string tag, input int data, input int idx, input bit last);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_data"}, out_data, data);
        chk({tag, "_idx"}, out_idx, idx);
        chk({tag, "_last"}, out_last, last);
    endtask

    task automatic idle(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_last"}, out_last, 0);
    endtask

    initial begin
        rst = 1'b1; res_write = 1'b0; res_in = '0; done = 1'b0; out_ready = 1'b0;
        #2;
        tick();
        rst = 1'b0;
        idle("reset");
        chk("reset_ovf", overflow_err, 0);
        chk("reset_data", out_data, 0);
        chk("reset_idx", out_idx, 0);

        // basic batch: 0x50 -> 5, negative -> 0, 0x10000 -> saturates to 255
        wr(20'h00050); wr(20'hFFFF0); wr(20'h10000);
        out_ready = 1'b1;
        pulse_done();
        beat("b1_0", 5, 0, 0);
        tick();
        beat("b1_1", 0, 1, 0);
        tick();
        beat("b1_2", 255, 2, 1);
        tick();
        idle("b1_end");

        // stall: out_ready low for three DRAIN cycles holds beat 0
        out_ready = 1'b0;
        wr(20'h00050); wr(20'hFFFF0); wr(20'h10000);
        pulse_done();
        for (int i = 0; i < 3; i++) begin
            beat("stall", 5, 0, 0);
            tick();
        end
        out_ready = 1'b1;
        beat("stall_go", 5, 0, 0);
        tick();
        beat("stall_1", 0, 1, 0);
        tick();
        beat("stall_2", 255, 2, 1);
        tick();
        idle("stall_end");
        chk("stall_ovf", overflow_err, 0);

        // overflow: 17 writes, the last is dropped
        for (int k = 0; k <= 16; k++) wr(20'(16 * k));
        chk("ovf_set", overflow_err, 1);
        pulse_done();
        for (int i = 0; i < 16; i++) begin
            beat("ovf_beat", i, i, i == 15);
            tick();
        end
        idle("ovf_end");
        chk("ovf_sticky", overflow_err, 1);

        // done with nothing stored
        pulse_done();
        idle("empty_0");
        tick();
        idle("empty_1");

        // write and done in the same cycle
        wr(20'h00010);
        res_write = 1'b1; res_in = 20'h00020; done = 1'b1;
        tick();
        res_write = 1'b0; done = 1'b0;
        beat("same_0", 1, 0, 0);
        tick();
        beat("same_1", 2, 1, 1);
        tick();
        idle("same_end");

        // reset mid-drain
        wr(20'h00050); wr(20'h00010); wr(20'h00020);
        pulse_done();
        beat("mid_0", 5, 0, 0);
        tick();
        beat("mid_1", 1, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle("mid_rst");
        chk("mid_rst_ovf", overflow_err, 0);
        chk("mid_rst_idx", out_idx, 0);
        wr(20'h00030);
        pulse_done();
        beat("post_0", 3, 0, 1);
        tick();
        idle("post_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
